instr_fetch: RTL and testbench



---
 rtl/instr_fetch_pkg.sv | 11 +
 rtl/instr_fetch_if.sv | 32 +++
 rtl/instr_fetch_fifo.sv | 72 +++++++
 rtl/instr_fetch.sv | 99 +++++++++
 tb/tb_instr_fetch.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared types and sizing for the instruction fetch front end.
package instr_fetch_pkg;
    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    localparam int INSTR_BYTES = 4;
    localparam int FIFO_DEPTH  = 2;
    localparam int CNT_W       = $clog2(FIFO_DEPTH + 1);
endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-side bus bundle: instruction memory port, redirect input and decode port.
interface instr_fetch_if #(
    parameter int unsigned XLEN = 32
);
    logic            o_imem_req;
    logic [XLEN-1:0] o_imem_addr;
    logic            i_imem_ack;
    logic [XLEN-1:0] i_imem_rdata;
    logic            i_redirect;
    logic [XLEN-1:0] i_redirect_pc;
    logic            o_instr_valid;
    logic            i_instr_ready;
    logic [XLEN-1:0] o_instr;
    logic [XLEN-1:0] o_instr_pc;
    logic [6:0]      o_opcode;

    modport master (
        output o_imem_req, o_imem_addr,
        input  i_imem_ack, i_imem_rdata,
        input  i_redirect, i_redirect_pc,
        output o_instr_valid, o_instr, o_instr_pc, o_opcode,
        input  i_instr_ready
    );

    modport slave (
        input  o_imem_req, o_imem_addr,
        output i_imem_ack, i_imem_rdata,
        output i_redirect, i_redirect_pc,
        input  o_instr_valid, o_instr, o_instr_pc, o_opcode,
        output i_instr_ready
    );
endinterface

// File: rtl/instr_fetch_fifo.sv
// Two-entry {pc, instr} FIFO; entry 0 is always the head, flush beats push.
module fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [XLEN-1:0]  i_push_pc,
    input  logic [XLEN-1:0]  i_push_instr,
    output logic [XLEN-1:0]  o_head_pc,
    output logic [XLEN-1:0]  o_head_instr,
    output logic [CNT_W-1:0] o_count
);
    logic [XLEN-1:0]  pc_q    [FIFO_DEPTH];
    logic [XLEN-1:0]  pc_d    [FIFO_DEPTH];
    logic [XLEN-1:0]  instr_q [FIFO_DEPTH];
    logic [XLEN-1:0]  instr_d [FIFO_DEPTH];
    logic [CNT_W-1:0] count_q, count_d, level;
    logic             push_ok;

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        count_d = count_q;
        level   = count_q;
        push_ok = 1'b0;
        if (i_flush) begin
            count_d = '0;
        end else begin
            if (i_pop && count_q != '0) begin
                for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                    pc_d[i]    = pc_q[i+1];
                    instr_d[i] = instr_q[i+1];
                end
                level = count_q - 1'b1;
            end
            // Push lands in the first free slot after any same-cycle pop.
            push_ok = i_push && (level != CNT_W'(FIFO_DEPTH));
            if (push_ok) begin
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    if (level == CNT_W'(i)) begin
                        pc_d[i]    = i_push_pc;
                        instr_d[i] = i_push_instr;
                    end
                end
            end
            count_d = level + {{(CNT_W-1){1'b0}}, push_ok};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            count_q <= count_d;
        end
    end

    assign o_head_pc    = pc_q[0];
    assign o_head_instr = instr_q[0];
    assign o_count      = count_q;
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front end: PC sequencing, one-outstanding memory reads,
// redirect handling with drain of an in-flight read, and a decode-side FIFO.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic           i_clk,
    input logic           i_rst_n,
    instr_fetch_if.master bus
);
    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] target_q, target_d;
    logic            pending_q, pending_d;
    logic            started_q, started_d;

    logic             req, ack_v, push, pop, flush;
    logic [XLEN-1:0]  redir_target, head_pc, head_instr;
    logic [CNT_W-1:0] count;

    assign redir_target = bus.i_redirect_pc & ~XLEN'(INSTR_BYTES - 1);

    // started_q keeps the request low for the whole reset and the release cycle.
    assign req   = started_q & (pending_q | (count <= CNT_W'(1)));
    assign ack_v = req & bus.i_imem_ack;
    assign pop   = (count != '0) & bus.i_instr_ready;
    assign flush = bus.i_redirect;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        target_d  = target_q;
        pending_d = req & ~ack_v;
        started_d = 1'b1;
        push      = 1'b0;
        unique case (state_q)
            RUN: begin
                if (bus.i_redirect) begin
                    if (req && !ack_v) begin
                        state_d  = DRAIN;
                        target_d = redir_target;
                    end else begin
                        pc_d = redir_target;
                    end
                end else if (ack_v) begin
                    push = 1'b1;
                    pc_d = pc_q + XLEN'(INSTR_BYTES);
                end
            end
            DRAIN: begin
                if (ack_v) begin
                    state_d = RUN;
                    pc_d    = bus.i_redirect ? redir_target : target_q;
                end else if (bus.i_redirect) begin
                    target_d = redir_target;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            target_q  <= '0;
            pending_q <= 1'b0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            target_q  <= target_d;
            pending_q <= pending_d;
            started_q <= started_d;
        end
    end

    fetch_fifo #(.XLEN(XLEN)) u_fifo (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_push       (push),
        .i_pop        (pop),
        .i_flush      (flush),
        .i_push_pc    (pc_q),
        .i_push_instr (bus.i_imem_rdata),
        .o_head_pc    (head_pc),
        .o_head_instr (head_instr),
        .o_count      (count)
    );

    assign bus.o_imem_req    = req;
    assign bus.o_imem_addr   = req ? pc_q : '0;
    assign bus.o_instr_valid = (count != '0);
    assign bus.o_instr       = head_instr;
    assign bus.o_instr_pc    = head_pc;
    assign bus.o_opcode      = head_instr[6:0];
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios followed by randomized memory
// latency, decode back-pressure and redirects, checked against a stream model.
module tb_instr_fetch;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    instr_fetch_if #(.XLEN(32)) bus ();

    instr_fetch #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Instruction memory contents: two fixed words, hash everywhere else.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h0010_0113;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Stream model: what decode must see and what address memory must be asked for.
    logic [31:0] exp_pc, fetch_pc, pend_pc, held_addr, prev_ipc, prev_instr;
    logic        draining, held, hold_head, expect_empty;
    int          pops = 0;

    task automatic model_update();
        logic        rq, ack_v;
        logic [31:0] tgt;
        rq = bus.o_imem_req;
        if (!rst_n) begin
            exp_pc = RESET_PC; fetch_pc = RESET_PC; pend_pc = '0;
            draining = 0; held = 0; hold_head = 0; expect_empty = 0;
        end else begin
            if (expect_empty) check("flush_empty", bus.o_instr_valid, 0);
            if (hold_head) begin
                check("head_hold_valid", bus.o_instr_valid, 1);
                check("head_hold_pc", bus.o_instr_pc, prev_ipc);
                check("head_hold_instr", bus.o_instr, prev_instr);
            end
            if (held) begin
                check("req_hold", rq, 1);
                check("addr_hold", bus.o_imem_addr, held_addr);
            end else if (rq) begin
                check("req_addr", bus.o_imem_addr, fetch_pc);
            end
            if (bus.o_instr_valid && bus.i_instr_ready) begin
                check("pop_pc", bus.o_instr_pc, exp_pc);
                check("pop_instr", bus.o_instr, mem_word(exp_pc));
                check("pop_opcode", bus.o_opcode, mem_word(exp_pc) & 32'h7F);
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            ack_v = rq && bus.i_imem_ack;
            if (bus.i_redirect) begin
                tgt = bus.i_redirect_pc & ~32'h3;
                exp_pc = tgt;
                if (rq && !ack_v) begin
                    draining = 1; pend_pc = tgt;
                end else begin
                    draining = 0; fetch_pc = tgt;
                end
            end else if (ack_v) begin
                if (draining) begin
                    fetch_pc = pend_pc; draining = 0;
                end else begin
                    fetch_pc = fetch_pc + 32'd4;
                end
            end
            held         = rq && !ack_v;
            held_addr    = bus.o_imem_addr;
            hold_head    = bus.o_instr_valid && !bus.i_instr_ready && !bus.i_redirect;
            prev_ipc     = bus.o_instr_pc;
            prev_instr   = bus.o_instr;
            expect_empty = bus.i_redirect;
        end
    endtask

    task automatic drive(input logic ack, input logic rdy, input logic redir, input logic [31:0] rpc);
        bus.i_imem_ack    = ack;
        bus.i_imem_rdata  = ack ? mem_word(bus.o_imem_addr) : 32'hDEAD_BEEF;
        bus.i_instr_ready = rdy;
        bus.i_redirect    = redir;
        bus.i_redirect_pc = rpc;
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_req", bus.o_imem_req, 0);
            check("rst_valid", bus.o_instr_valid, 0);
            check("rst_addr", bus.o_imem_addr, 0);
            check("rst_instr", bus.o_instr, 0);
            check("rst_instr_pc", bus.o_instr_pc, 0);
            tick();
        end
        rst_n = 1'b1;
        tick();
    endtask

    logic        r_ack, r_redir;
    logic [31:0] r_pc;
    int          mem_wait = 0;
    logic        mem_busy = 1'b0;

    initial begin
        drive(0, 0, 0, 0);
        @(negedge clk);

        // Reset and first request
        do_reset();
        check("t1_first_req", bus.o_imem_req, 1);
        check("t1_first_addr", bus.o_imem_addr, RESET_PC);

        // Zero-wait memory, decode always ready
        drive(1, 1, 0, 0); tick();
        check("t2_valid0", bus.o_instr_valid, 1);
        check("t2_pc0", bus.o_instr_pc, 32'h0);
        check("t2_instr0", bus.o_instr, 32'h0050_0093);
        check("t2_opc0", bus.o_opcode, 32'h13);
        drive(1, 1, 0, 0); tick();
        check("t2_valid1", bus.o_instr_valid, 1);
        check("t2_pc1", bus.o_instr_pc, 32'h4);
        check("t2_opc1", bus.o_opcode, 32'h13);
        check("t2_addr", bus.o_imem_addr, 32'h8);

        // FIFO fills under back-pressure, then drains in order
        do_reset();
        drive(1, 0, 0, 0); tick();
        check("t3_addr4", bus.o_imem_addr, 32'h4);
        drive(1, 0, 0, 0); tick();
        check("t3_req_full", bus.o_imem_req, 0);
        check("t3_head0", bus.o_instr_pc, 32'h0);
        drive(1, 0, 0, 0); tick();
        check("t3_req_ignore_ack", bus.o_imem_req, 0);
        drive(0, 1, 0, 0); tick();
        check("t3_head4", bus.o_instr_pc, 32'h4);
        check("t3_req_resume", bus.o_imem_req, 1);
        check("t3_addr8", bus.o_imem_addr, 32'h8);
        drive(0, 1, 0, 0); tick();
        check("t3_empty", bus.o_instr_valid, 0);

        // Redirect while a read is outstanding
        do_reset();
        drive(1, 1, 0, 0); tick();
        check("t4_addr4", bus.o_imem_addr, 32'h4);
        drive(0, 1, 0, 0); tick();
        drive(0, 1, 1, 32'h100); tick();
        check("t4_drain_req", bus.o_imem_req, 1);
        check("t4_drain_addr", bus.o_imem_addr, 32'h4);
        check("t4_drain_valid", bus.o_instr_valid, 0);
        drive(0, 1, 0, 0); tick();
        check("t4_drain_addr2", bus.o_imem_addr, 32'h4);
        drive(1, 1, 0, 0); tick();
        check("t4_target_addr", bus.o_imem_addr, 32'h100);
        check("t4_no_push", bus.o_instr_valid, 0);

        // Redirect in an ack cycle with one entry buffered
        drive(1, 0, 0, 0); tick();
        check("t5_count1", bus.o_instr_pc, 32'h100);
        drive(1, 0, 1, 32'h203); tick();
        check("t5_flushed", bus.o_instr_valid, 0);
        check("t5_addr", bus.o_imem_addr, 32'h200);
        drive(1, 1, 0, 0); tick();
        check("t5_head", bus.o_instr_pc, 32'h200);

        // Asynchronous reset while draining
        drive(0, 0, 1, 32'h300); tick();
        check("t6_drain_addr", bus.o_imem_addr, 32'h204);
        drive(0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_req", bus.o_imem_req, 0);
        check("t6_async_valid", bus.o_instr_valid, 0);
        @(negedge clk);
        do_reset();
        check("t6_req", bus.o_imem_req, 1);
        check("t6_addr", bus.o_imem_addr, RESET_PC);

        // Randomized latency, back-pressure and redirects (including near wrap)
        mem_busy = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (bus.o_imem_req) begin
                if (!mem_busy) begin
                    mem_wait = $urandom_range(0, 3);
                    mem_busy = 1'b1;
                end
                if (mem_wait == 0) begin
                    r_ack = 1'b1; mem_busy = 1'b0;
                end else begin
                    r_ack = 1'b0; mem_wait--;
                end
            end else begin
                r_ack = ($urandom_range(0, 3) == 0);
            end
            r_redir = ($urandom_range(0, 15) == 0);
            r_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            drive(r_ack, $urandom_range(0, 3) != 0, r_redir, r_pc);
            tick();
        end
        check("liveness", 32'(pops > 500), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
